// File: rtl/mul_ctrl_pkg.sv
// Shared op-codes and helpers for the multiplier issue/retire controller.
package mul_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  // Cycles between presenting operands to mul and its result being valid.
  localparam int MUL_LAT = 1;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MUL);
  endfunction

  function automatic logic is_mf_op(input logic [2:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/mul_ctrl_hilo_regs.sv
// Architectural HI/LO registers: a product write port and a move write port,
// where the move (always the younger instruction) wins its register.
module hilo_regs
  import mul_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            prod_we_i,
  input  logic [2*DW-1:0] prod_i,
  input  logic            mv_hi_we_i,
  input  logic            mv_lo_we_i,
  input  logic [DW-1:0]   mv_data_i,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (prod_we_i) begin
      hi_d = prod_i[2*DW-1:DW];
      lo_d = prod_i[DW-1:0];
    end
    if (mv_hi_we_i) hi_d = mv_data_i;
    if (mv_lo_we_i) lo_d = mv_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_ctrl.sv
// Issue/retire controller around the external 2-stage multiplier: drives its
// operands, retires products into HI/LO or GPR write-back, interlocks MFHI/MFLO.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DW    = 32
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [DW-1:0]    req_x,
  input  logic [DW-1:0]    req_y,
  input  logic [TAG_W-1:0] req_tag,
  output logic [DW-1:0]    mul_x,
  output logic [DW-1:0]    mul_y,
  output logic             mul_signed,
  input  logic [2*DW-1:0]  mul_result,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [DW-1:0]    wb_data,
  output logic [DW-1:0]    hi,
  output logic [DW-1:0]    lo,
  output logic             busy
);

  logic             acc;
  logic             issue;
  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             prod_we;
  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;

  // A move-from must wait until no product is in flight, so it sees the fresh
  // HI/LO and can never collide with a MUL write-back.
  assign req_ready = !(is_mf_op(req_op) && s1_valid_q);
  assign acc       = req_valid && req_ready;
  assign issue     = acc && is_mul_op(req_op);

  assign mul_x      = issue ? req_x : '0;
  assign mul_y      = issue ? req_y : '0;
  assign mul_signed = issue && is_signed_op(req_op);

  always_ff @(posedge mul_clk) begin
    if (!resetn) s1_valid_q <= 1'b0;
    else         s1_valid_q <= issue;
  end

  always_ff @(posedge mul_clk) begin
    if (issue) begin
      s1_op_q  <= req_op;
      s1_tag_q <= req_tag;
    end
  end

  assign busy    = s1_valid_q;
  assign prod_we = s1_valid_q && (s1_op_q != OP_MUL);

  always_comb begin
    wb_valid_d = 1'b0;
    wb_tag_d   = wb_tag_q;
    wb_data_d  = wb_data_q;
    if (s1_valid_q && (s1_op_q == OP_MUL)) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = s1_tag_q;
      wb_data_d  = mul_result[DW-1:0];
    end else if (acc && is_mf_op(req_op)) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = req_tag;
      wb_data_d  = (req_op == OP_MFHI) ? hi : lo;
    end
  end

  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_tag   = wb_tag_q;
  assign wb_data  = wb_data_q;

  hilo_regs #(.DW(DW)) u_hilo (
    .clk_i      (mul_clk),
    .resetn_i   (resetn),
    .prod_we_i  (prod_we),
    .prod_i     (mul_result),
    .mv_hi_we_i (acc && (req_op == OP_MTHI)),
    .mv_lo_we_i (acc && (req_op == OP_MTLO)),
    .mv_data_i  (req_x),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl with a behavioural multiplier stub and a
// transaction-level HI/LO / write-back model.
module tb_mul_ctrl;
  import mul_ctrl_pkg::*;

  logic        mul_clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_x, req_y;
  logic [4:0]  req_tag;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic [31:0] hi, lo;
  logic        busy;

  always #5 mul_clk = ~mul_clk;

  mul_ctrl #(.TAG_W(5), .DW(32)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_tag    (req_tag),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_data    (wb_data),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy)
  );

  // External multiplier stand-in: result valid one cycle after operands.
  always @(posedge mul_clk) begin
    if (mul_signed)
      mul_result <= 64'($signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y}));
    else
      mul_result <= {32'b0, mul_x} * {32'b0, mul_y};
  end

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference state: architectural HI/LO and the single product in flight.
  logic [31:0] m_hi, m_lo;
  logic        m_busy;
  logic [2:0]  m_op;
  logic [4:0]  m_tag;
  logic [63:0] m_prod;

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (op == OP_MULTU) return {32'b0, x} * {32'b0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge mul_clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got tag %0d data %h expected no write-back (t=%0t)", wb_tag, wb_data, $time);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_tag", 64'(wb_tag), 64'(e.tag));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  // One request cycle; entered and left just after a rising edge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] tag, output logic acc);
    logic        exp_rdy;
    logic [31:0] pre_hi, pre_lo;
    req_valid = v;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_tag   = tag;
    @(negedge mul_clk);
    exp_rdy = !(((op == OP_MFHI) || (op == OP_MFLO)) && m_busy);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("mul_signed", 64'(mul_signed), 64'(acc && ((op == OP_MULT) || (op == OP_MUL))));
    chk("mul_x", 64'(mul_x), 64'((acc && op <= OP_MUL) ? x : 32'h0));
    chk("mul_y", 64'(mul_y), 64'((acc && op <= OP_MUL) ? y : 32'h0));
    @(posedge mul_clk);
    pre_hi = m_hi;
    pre_lo = m_lo;
    if (m_busy) begin
      if (m_op == OP_MUL) exp_q.push_back({m_tag, m_prod[31:0]});
      else begin
        m_hi = m_prod[63:32];
        m_lo = m_prod[31:0];
      end
    end
    m_busy = acc && (op <= OP_MUL);
    if (m_busy) begin
      m_op   = op;
      m_tag  = tag;
      m_prod = ref_prod(op, x, y);
    end
    if (acc && op == OP_MFHI) exp_q.push_back({tag, pre_hi});
    if (acc && op == OP_MFLO) exp_q.push_back({tag, pre_lo});
    if (acc && op == OP_MTHI) m_hi = x;
    if (acc && op == OP_MTLO) m_lo = x;
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, OP_NOP, 32'h0, 32'h0, 5'h0, a);
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    req_op    = OP_NOP;
    resetn    = 1'b0;
    @(posedge mul_clk);
    m_hi   = '0;
    m_lo   = '0;
    m_busy = 1'b0;
    exp_q.delete();
    #1;
    resetn = 1'b1;
  endtask

  logic        a;
  logic [31:0] rx, ry;
  logic [2:0]  rop;

  initial begin
    resetn = 1'b0;
    req_valid = 1'b0; req_op = OP_NOP; req_x = '0; req_y = '0; req_tag = '0;
    m_hi = '0; m_lo = '0; m_busy = 1'b0; m_op = OP_NOP; m_tag = '0; m_prod = '0;
    @(posedge mul_clk);
    apply_reset();
    @(negedge mul_clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_wb_tag", 64'(wb_tag), 64'h0);
    chk("rst_wb_data", 64'(wb_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(posedge mul_clk);
    #1;

    // MULTU / MULT with the all-ones operand
    cycle(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'h2, 5'd0, a);
    idle(1);
    chk("t1_hi", 64'(hi), 64'h1);
    chk("t1_lo", 64'(lo), 64'hFFFFFFFE);
    idle(1);
    cycle(1'b1, OP_MULT, 32'hFFFFFFFF, 32'h2, 5'd0, a);
    idle(1);
    chk("t2_hi", 64'(hi), 64'hFFFFFFFF);
    chk("t2_lo", 64'(lo), 64'hFFFFFFFE);

    // MUL write-back two cycles after accept
    cycle(1'b1, OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, a);
    idle(1);
    chk("t3_wb_valid", 64'(wb_valid), 64'h1);
    chk("t3_wb_tag", 64'(wb_tag), 64'd5);
    chk("t3_wb_data", 64'(wb_data), 64'hFFFFFFEB);
    chk("t3_hi", 64'(hi), 64'hFFFFFFFF);
    idle(1);

    // MFLO stalled behind an in-flight MULT
    cycle(1'b1, OP_MULT, 32'd3, 32'd4, 5'd0, a);
    cycle(1'b1, OP_MFLO, 32'h0, 32'h0, 5'd9, a);
    chk("t4_first_try_stalled", 64'(a), 64'h0);
    cycle(1'b1, OP_MFLO, 32'h0, 32'h0, 5'd9, a);
    chk("t4_wb_data", 64'(wb_data), 64'hC);
    chk("t4_wb_tag", 64'(wb_tag), 64'd9);
    idle(1);

    // MTHI accepted while a MULT retires
    cycle(1'b1, OP_MULT, 32'd3, 32'd4, 5'd0, a);
    cycle(1'b1, OP_MTHI, 32'hDEADBEEF, 32'h0, 5'd0, a);
    chk("t5_hi", 64'(hi), 64'hDEADBEEF);
    chk("t5_lo", 64'(lo), 64'hC);

    // Reset with a product in flight
    cycle(1'b1, OP_MULT, 32'd5, 32'd6, 5'd0, a);
    apply_reset();
    chk("t6_busy", 64'(busy), 64'h0);
    idle(2);
    chk("t6_hi", 64'(hi), 64'h0);
    chk("t6_lo", 64'(lo), 64'h0);
    chk("t6_wb_valid", 64'(wb_valid), 64'h0);

    // Randomized mix with back-to-back traffic
    for (int i = 0; i < 400; i++) begin
      rx  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
      ry  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom();
      rop = 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, rop, rx, ry, 5'($urandom()), a);
    end
    idle(3);
    chk("wb_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
